// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl -- pipeline scheduler for the 5-stage ARM core.
//
// Keeps a 16-entry register scoreboard (one bit per register with an
// in-flight writer), raises `hazard` into ID on RAW/WAW conflicts,
// sequences the branch flush and the multi-cycle data-memory stall.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   id_*                decoded fields of the instruction sitting in ID
//   exe_branch          taken branch resolved in EXE
//   mem_req, mem_ready  MEM-stage data access handshake
//   wb_en, wb_dest      write-back retire
//   hazard              squash ID control, hold IF/ID
//   issue               instruction leaves ID this cycle
//   flush               clear IF/ID and ID/EXE
//   freeze              hold all pipe registers and PC
//   pending             scoreboard view
//   mem_err             sticky memory-timeout flag
//   stall_cycles        saturating count of hazard|freeze cycles
//
// Optional feature: define HAZARD_SCHED_STATS_EN to build the stall
// counter; otherwise stall_cycles is tied to zero.
module hazard_sched_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        exe_branch,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  output logic        hazard,
  output logic        issue,
  output logic        flush,
  output logic        freeze,
  output logic [15:0] pending,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic {F_IDLE, F_FLUSH} flushState_t;
  typedef enum logic {M_IDLE, M_WAIT}  memState_t;

  flushState_t flushState;
  logic [3:0]  flushCnt;
  memState_t   memState;
  logic [15:0] memCnt;
  logic [15:0] pendNext;
  logic        memTimeout;

  // Timeout is reached in WAIT when the counter hits the limit while the
  // access is still outstanding; freeze is released in that same cycle.
  assign memTimeout = (memState == M_WAIT) && (memCnt == 16'(MEM_TIMEOUT))
                      && mem_req && !mem_ready;

  // Combinational outputs are qualified with rst so they read 0 the moment
  // reset asserts, even while MEM still requests or ID still holds an op.
  always_comb begin
    hazard = rst && id_valid &&
             (pending[id_src1] ||
              (id_two_src && pending[id_src2]) ||
              (id_wb_en && pending[id_dest]));
    freeze = rst && mem_req && !mem_ready && !memTimeout;
    flush  = rst && ((exe_branch && !freeze) || (flushState == F_FLUSH));
    issue  = rst && id_valid && !hazard && !freeze && !flush;
  end

  // Retire first, then set, so a same-cycle set/clear on one register
  // leaves it pending. Retire is not gated by freeze; set is via issue.
  always_comb begin
    pendNext = pending;
    if (wb_en)
      pendNext[wb_dest] = 1'b0;
    if (issue && id_wb_en)
      pendNext[id_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= pendNext;
  end

  // Flush FSM: holds entirely while frozen, so a branch held in a frozen
  // EXE is taken once the freeze lifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushState <= F_IDLE;
      flushCnt   <= '0;
    end else if (!freeze) begin
      case (flushState)
        F_IDLE: begin
          if (exe_branch && (FLUSH_CYCLES > 1)) begin
            flushState <= F_FLUSH;
            flushCnt   <= 4'(FLUSH_CYCLES - 1);
          end
        end
        F_FLUSH: begin
          if (exe_branch) begin
            flushCnt <= 4'(FLUSH_CYCLES - 1);
          end else if (flushCnt == 4'd1) begin
            flushState <= F_IDLE;
            flushCnt   <= '0;
          end else begin
            flushCnt <= flushCnt - 4'd1;
          end
        end
        default: begin
          flushState <= F_IDLE;
          flushCnt   <= '0;
        end
      endcase
    end
  end

  // Mem FSM: counts consecutive wait cycles of one outstanding access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memState <= M_IDLE;
      memCnt   <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (memState)
        M_IDLE: begin
          if (mem_req && !mem_ready) begin
            memState <= M_WAIT;
            memCnt   <= 16'd1;
          end
        end
        M_WAIT: begin
          if (!mem_req || mem_ready) begin
            memState <= M_IDLE;
            memCnt   <= '0;
          end else if (memTimeout) begin
            memState <= M_IDLE;
            memCnt   <= '0;
            mem_err  <= 1'b1;
          end else begin
            memCnt <= memCnt + 16'd1;
          end
        end
        default: begin
          memState <= M_IDLE;
          memCnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_SCHED_STATS_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stallCnt <= '0;
    else if ((hazard || freeze) && (stallCnt != '1))
      stallCnt <= stallCnt + 32'd1;
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
